// File: rtl/hud_pkg.sv
// Shared encodings, colours and slot geometry helper for the lives HUD.
package hud_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SLOT_W  = 11;

    localparam logic [1:0] ST_PLAY     = 2'd0;
    localparam logic [1:0] ST_INVULN   = 2'd1;
    localparam logic [1:0] ST_GAMEOVER = 2'd2;

    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_RED   = 3'b100;

    // Left x of icon slot idx; widened so slots past the screen edge never wrap.
    function automatic logic [SLOT_W-1:0] slot_x0(
        input int unsigned idx,
        input int unsigned x0,
        input int unsigned w,
        input int unsigned gap
    );
        return SLOT_W'(x0 + idx * (w + gap));
    endfunction

endpackage

// File: rtl/vidas_icon_row.sv
// Combinational slot decoder: flags which life-icon slot, if any, covers the current pixel.
module vidas_icon_row
    import hud_pkg::*;
#(
    parameter int unsigned MAX_LIVES = 7,
    parameter int unsigned ICON_X0   = 16,
    parameter int unsigned ICON_Y0   = 16,
    parameter int unsigned ICON_W    = 16,
    parameter int unsigned ICON_H    = 16,
    parameter int unsigned ICON_GAP  = 8
) (
    input  logic [COORD_W-1:0]   pix_x,
    input  logic [COORD_W-1:0]   pix_y,
    output logic [MAX_LIVES-1:0] slot_hit
);

    localparam logic [SLOT_W-1:0] Y_LO = SLOT_W'(ICON_Y0);
    localparam logic [SLOT_W-1:0] Y_HI = SLOT_W'(ICON_Y0 + ICON_H);

    logic [SLOT_W-1:0] w_x;
    logic [SLOT_W-1:0] w_y;
    logic              w_y_in;

    assign w_x    = SLOT_W'(pix_x);
    assign w_y    = SLOT_W'(pix_y);
    assign w_y_in = (w_y >= Y_LO) && (w_y < Y_HI);

    for (genvar gi = 0; gi < MAX_LIVES; gi++) begin : g_slot
        localparam logic [SLOT_W-1:0] X_LO = slot_x0(gi, ICON_X0, ICON_W, ICON_GAP);
        localparam logic [SLOT_W-1:0] X_HI = X_LO + SLOT_W'(ICON_W);
        assign slot_hit[gi] = w_y_in && (w_x >= X_LO) && (w_x < X_HI);
    end

endmodule

// File: rtl/vidas_hud_ctrl.sv
// Lives manager (hit / bonus / invulnerability / game over) and HUD icon renderer
// feeding pixel_mux with a 1-clk registered colour.
module vidas_hud_ctrl
    import hud_pkg::*;
#(
    parameter int unsigned MAX_LIVES     = 7,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned BLINK_BIT     = 3,
    parameter int unsigned ICON_X0       = 16,
    parameter int unsigned ICON_Y0       = 16,
    parameter int unsigned ICON_W        = 16,
    parameter int unsigned ICON_H        = 16,
    parameter int unsigned ICON_GAP      = 8,
    parameter logic [2:0]  ICON_RGB      = RGB_RED
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hit,
    input  logic               extra_life,
    input  logic               restart,
    input  logic               frame_tick,
    input  logic               video_on,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic [3:0]         lives,
    output logic               invuln,
    output logic               game_over,
    output logic [2:0]         vidas_rgb,
    output logic               vidas_on
);

    localparam int unsigned BLINK_W = BLINK_BIT + 1;
    localparam int unsigned TIMER_W = 8;

    logic [1:0]           r_state,  w_state_nxt;
    logic [3:0]           r_lives,  w_lives_nxt;
    logic [3:0]           w_lives_inc;
    logic [TIMER_W-1:0]   r_timer,  w_timer_nxt;
    logic [BLINK_W-1:0]   r_blink,  w_blink_nxt;
    logic                 r_hit_d;
    logic                 w_hit_rise;

    logic [MAX_LIVES-1:0] w_slot_hit;
    logic [MAX_LIVES-1:0] w_life_mask;
    logic                 w_blank;
    logic                 w_icon_lit;
    logic                 w_mask_lit;
    logic                 r_vidas_on;
    logic [2:0]           r_vidas_rgb;

    assign w_hit_rise  = hit & ~r_hit_d;
    assign w_lives_inc = (r_lives >= 4'(MAX_LIVES)) ? r_lives : r_lives + 4'd1;

    // State and counters register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_PLAY;
            r_lives <= 4'(START_LIVES);
            r_timer <= '0;
            r_blink <= '0;
            r_hit_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lives <= w_lives_nxt;
            r_timer <= w_timer_nxt;
            r_blink <= w_blink_nxt;
            r_hit_d <= hit;
        end
    end

    // Next state: restart overrides everything; a same-cycle hit+bonus is never fatal
    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_timer_nxt = r_timer;
        w_blink_nxt = r_blink + BLINK_W'(frame_tick);

        if (restart) begin
            w_state_nxt = ST_PLAY;
            w_lives_nxt = 4'(START_LIVES);
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_hit_rise && (extra_life || r_lives > 4'd1)) begin
                        w_state_nxt = ST_INVULN;
                        w_timer_nxt = TIMER_W'(INVULN_FRAMES);
                        w_blink_nxt = '0;
                        if (!extra_life) begin
                            w_lives_nxt = r_lives - 4'd1;
                        end
                    end else if (w_hit_rise) begin
                        w_state_nxt = ST_GAMEOVER;
                        w_lives_nxt = 4'd0;
                    end else if (extra_life) begin
                        w_lives_nxt = w_lives_inc;
                    end
                end
                ST_INVULN: begin
                    if (extra_life) begin
                        w_lives_nxt = w_lives_inc;
                    end
                    if (r_timer == '0) begin
                        w_state_nxt = ST_PLAY;
                    end else if (frame_tick) begin
                        w_timer_nxt = r_timer - TIMER_W'(1);
                    end
                end
                ST_GAMEOVER: begin
                    w_lives_nxt = 4'd0;
                end
                default: begin
                    w_state_nxt = ST_PLAY;
                end
            endcase
        end
    end

    assign lives     = r_lives;
    assign invuln    = (r_state == ST_INVULN);
    assign game_over = (r_state == ST_GAMEOVER);

    vidas_icon_row #(
        .MAX_LIVES (MAX_LIVES),
        .ICON_X0   (ICON_X0),
        .ICON_Y0   (ICON_Y0),
        .ICON_W    (ICON_W),
        .ICON_H    (ICON_H),
        .ICON_GAP  (ICON_GAP)
    ) u_icon_row (
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .slot_hit (w_slot_hit)
    );

    for (genvar gi = 0; gi < MAX_LIVES; gi++) begin : g_life
        assign w_life_mask[gi] = (4'(gi) < r_lives);
    end

    assign w_blank    = (r_state == ST_INVULN) && r_blink[BLINK_BIT];
    assign w_icon_lit = video_on && (|(w_slot_hit & w_life_mask)) && !w_blank
                        && (r_state != ST_GAMEOVER);
    assign w_mask_lit = video_on && (|w_slot_hit) && (r_state == ST_GAMEOVER);

    // Colour register: one clk behind pix_x/pix_y, matched by vga_sync
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vidas_on  <= 1'b0;
            r_vidas_rgb <= RGB_BLACK;
        end else begin
            r_vidas_on  <= w_icon_lit || w_mask_lit;
            r_vidas_rgb <= w_icon_lit ? ICON_RGB : RGB_BLACK;
        end
    end

    assign vidas_on  = r_vidas_on;
    assign vidas_rgb = r_vidas_rgb;

endmodule

// File: tb/tb_vidas_hud_ctrl.sv
// Bench for vidas_hud_ctrl: directed scenarios plus random traffic, every cycle
// compared against a rule-level model of lives, mode and HUD pixels.
module tb_vidas_hud_ctrl;

    localparam int M_PLAY = 0;
    localparam int M_INV  = 1;
    localparam int M_GO   = 2;

    logic       clk;
    logic       reset;
    logic       hit;
    logic       extra_life;
    logic       restart;
    logic       frame_tick;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [3:0] lives;
    logic       invuln;
    logic       game_over;
    logic [2:0] vidas_rgb;
    logic       vidas_on;

    int n_checks;
    int n_pass;

    int m_lives;
    int m_mode;
    int m_timer;
    int m_blink;
    bit m_hit_prev;

    vidas_hud_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .hit        (hit),
        .extra_life (extra_life),
        .restart    (restart),
        .frame_tick (frame_tick),
        .video_on   (video_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .lives      (lives),
        .invuln     (invuln),
        .game_over  (game_over),
        .vidas_rgb  (vidas_rgb),
        .vidas_on   (vidas_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_lives    = 3;
        m_mode     = M_PLAY;
        m_timer    = 0;
        m_blink    = 0;
        m_hit_prev = 1'b0;
    endtask

    // Expected HUD pixel for the current inputs and model state
    function automatic void model_render(output bit on, output int rgb);
        bit in_any = 1'b0;
        bit lit    = 1'b0;
        on  = 1'b0;
        rgb = 0;
        for (int i = 0; i < 7; i++) begin
            int x0 = 16 + i * 24;
            if (pix_x >= x0 && pix_x < x0 + 16 && pix_y >= 16 && pix_y < 32) begin
                in_any = 1'b1;
                if (i < m_lives) lit = 1'b1;
            end
        end
        if (!video_on) return;
        if (m_mode == M_GO) begin
            on = in_any;
        end else if (lit && !(m_mode == M_INV && ((m_blink >> 3) & 1) == 1)) begin
            on  = 1'b1;
            rgb = 4;
        end
    endfunction

    // One clock: predict, advance the DUT, compare every output
    task automatic step();
        bit e_on;
        int e_rgb;
        int n_l, n_m, n_t, n_b;
        bit rise;
        model_render(e_on, e_rgb);
        rise = hit && !m_hit_prev;
        n_l  = m_lives;
        n_m  = m_mode;
        n_t  = m_timer;
        n_b  = frame_tick ? m_blink + 1 : m_blink;
        if (restart) begin
            n_l = 3; n_m = M_PLAY; n_t = 0;
        end else if (m_mode == M_PLAY) begin
            if (rise && extra_life) begin
                n_m = M_INV; n_t = 60; n_b = 0;
            end else if (rise && m_lives > 1) begin
                n_l = m_lives - 1; n_m = M_INV; n_t = 60; n_b = 0;
            end else if (rise) begin
                n_l = 0; n_m = M_GO;
            end else if (extra_life) begin
                n_l = (m_lives + 1 > 7) ? 7 : m_lives + 1;
            end
        end else if (m_mode == M_INV) begin
            if (extra_life) n_l = (m_lives + 1 > 7) ? 7 : m_lives + 1;
            if (m_timer == 0) n_m = M_PLAY;
            else if (frame_tick) n_t = m_timer - 1;
        end
        @(posedge clk);
        #1;
        m_lives = n_l; m_mode = n_m; m_timer = n_t; m_blink = n_b;
        m_hit_prev = hit;
        check("lives", int'(lives), m_lives);
        check("invuln", int'(invuln), int'(m_mode == M_INV));
        check("game_over", int'(game_over), int'(m_mode == M_GO));
        check("vidas_on", int'(vidas_on), int'(e_on));
        check("vidas_rgb", int'(vidas_rgb), e_rgb);
    endtask

    task automatic drive(input bit h, input bit xl, input bit rs, input bit ft);
        hit = h; extra_life = xl; restart = rs; frame_tick = ft;
        step();
        extra_life = 1'b0; restart = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            drive(hit, 1'b0, 1'b0, 1'b1);
            drive(hit, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic set_pix(input int x, input int y);
        pix_x = 10'(x);
        pix_y = 10'(y);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1; hit = 1'b0; extra_life = 1'b0; restart = 1'b0;
        frame_tick = 1'b0; video_on = 1'b0; pix_x = '0; pix_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_lives", int'(lives), 3);
        check("rst_invuln", int'(invuln), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_vidas_on", int'(vidas_on), 0);
        check("rst_vidas_rgb", int'(vidas_rgb), 0);
        reset = 1'b0;

        // Three spaced hits run the lives out
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check("hit_seq_lives", int'(lives), 2 - k);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            if (k < 2) ticks(62);
        end
        check("hit_seq_game_over", int'(game_over), 1);

        video_on = 1'b1;
        set_pix(16, 16);
        drive(1'b0, 1'b0, 1'b0, 0);
        check("go_mask_on", int'(vidas_on), 1);
        check("go_mask_rgb", int'(vidas_rgb), 0);
        drive(1'b1, 1'b1, 1'b0, 0);
        check("go_ignores_inputs", int'(lives), 0);
        drive(1'b0, 1'b0, 1'b1, 0);
        check("restart_lives", int'(lives), 3);
        check("restart_go", int'(game_over), 0);

        // Long hit level counts once; edges inside the window are ignored
        repeat (100) drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("held_hit_lives", int'(lives), 2);
        check("held_hit_invuln", int'(invuln), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 60; t++) begin
            drive((t % 7) == 3, 1'b0, 1'b0, 1'b1);
            if (t == 60) check("inv_after_last_tick", int'(invuln), 1);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("inv_expired", int'(invuln), 0);
        check("inv_lives_kept", int'(lives), 2);

        // Saturation at MAX_LIVES
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_reach_max", int'(lives), 7);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_hold_max", int'(lives), 7);

        // Same-cycle hit + bonus at one life
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(62);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(62);
        check("one_life", int'(lives), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("hit_xl_lives", int'(lives), 1);
        check("hit_xl_invuln", int'(invuln), 1);
        check("hit_xl_not_go", int'(game_over), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(62);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("restart_hit_lives", int'(lives), 3);
        check("restart_hit_play", int'(invuln), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Pixel sweep at two lives
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(62);
        set_pix(16, 16); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pix_slot0_on", int'(vidas_on), 1);
        check("pix_slot0_rgb", int'(vidas_rgb), 4);
        set_pix(40, 16); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pix_slot1_on", int'(vidas_on), 1);
        set_pix(64, 16); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pix_slot2_dark", int'(vidas_on), 0);
        set_pix(32, 16); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pix_gap_dark", int'(vidas_on), 0);
        set_pix(31, 31); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pix_corner_on", int'(vidas_on), 1);
        set_pix(16, 32); drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pix_below_dark", int'(vidas_on), 0);

        // Blink during invulnerability
        set_pix(16, 16);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(7);
        check("blink_phase_on", int'(vidas_on), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("blink_phase_dark", int'(vidas_on), 0);
        ticks(60);

        // Asynchronous reset mid-frame
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_async_on", int'(vidas_on), 1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_on", int'(vidas_on), 0);
        check("async_rst_lives", int'(lives), 3);
        model_reset();
        #1 reset = 1'b0;

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            bit h;
            h = ($urandom_range(0, 7) == 0) ? !hit : hit;
            video_on = ($urandom_range(0, 7) != 0);
            set_pix($urandom_range(0, 199), $urandom_range(0, 47));
            drive(h, $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
